// File: rtl/id_operand_latch_pkg.sv
// rtl/id_operand_latch_pkg.sv - shared widths, stall-bus index and FSM state encoding
package id_operand_latch_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_ADDR_W  = 5;
    localparam int DEFAULT_STALL_W = 6;   // [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
    localparam int DEFAULT_ID_BIT  = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,   // outputs follow the resolved operands
        ST_LWAIT = 2'd1,   // load-use seen; load data arrives via bypass next cycle
        ST_HOLD  = 2'd2    // ID stalled; outputs come from the hold registers
    } lat_state_e;

endpackage

// File: rtl/id_operand_latch_if.sv
// rtl/id_operand_latch_if.sv - operand/bypass/stall bundle between ID-stage logic and the operand latch
//   master: ID stage / bypass / ctrl side (drives operands, flush, stall; receives final operands)
//   slave : id_operand_latch
interface id_operand_latch_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6
) ();
    logic               flush;
    logic [STALL_W-1:0] stall;
    logic               rs_re_i;
    logic               rt_re_i;
    logic [ADDR_W-1:0]  rs_raddr_i;
    logic [ADDR_W-1:0]  rt_raddr_i;
    logic [DATA_W-1:0]  rs_rf_rdata_i;
    logic [DATA_W-1:0]  rt_rf_rdata_i;
    logic               sel_rs_forward_i;
    logic [DATA_W-1:0]  rs_forward_data_i;
    logic               sel_rt_forward_i;
    logic [DATA_W-1:0]  rt_forward_data_i;
    logic               ex_load_i;
    logic [ADDR_W-1:0]  ex_load_waddr_i;
    logic [DATA_W-1:0]  rs_data_o;
    logic [DATA_W-1:0]  rt_data_o;
    logic               stallreq_load_o;

    modport master (
        output flush, stall, rs_re_i, rt_re_i, rs_raddr_i, rt_raddr_i,
               rs_rf_rdata_i, rt_rf_rdata_i, sel_rs_forward_i, rs_forward_data_i,
               sel_rt_forward_i, rt_forward_data_i, ex_load_i, ex_load_waddr_i,
        input  rs_data_o, rt_data_o, stallreq_load_o
    );

    modport slave (
        input  flush, stall, rs_re_i, rt_re_i, rs_raddr_i, rt_raddr_i,
               rs_rf_rdata_i, rt_rf_rdata_i, sel_rs_forward_i, rs_forward_data_i,
               sel_rt_forward_i, rt_forward_data_i, ex_load_i, ex_load_waddr_i,
        output rs_data_o, rt_data_o, stallreq_load_o
    );
endinterface

// File: rtl/id_operand_latch_operand_mux.sv
// rtl/id_operand_latch_operand_mux.sv - per-operand resolve ($0 force, forward select) plus hold register
//   clk        : clock
//   clear      : synchronous clear of the hold register (reset or flush)
//   capture    : load the resolved value into the hold register
//   sel_hold   : drive the held value instead of the resolved one
//   kill       : force the output to zero (reset cycle)
//   raddr/sel_fwd/fwd_data/rf_rdata : operand sources
//   data_o     : final operand
module id_operand_latch_operand_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              capture,
    input  logic              sel_hold,
    input  logic              kill,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              sel_fwd,
    input  logic [DATA_W-1:0] fwd_data,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DATA_W-1:0] data_o
);
    logic [DATA_W-1:0] resolved;
    logic [DATA_W-1:0] hold_q;

    // $0 wins over any bypass hit: a forward targeting $0 is meaningless.
    always_comb begin
        resolved = '0;
        if (raddr != '0) begin
            resolved = sel_fwd ? fwd_data : rf_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= resolved;
        end
    end

    always_comb begin
        data_o = '0;
        if (!kill) begin
            data_o = sel_hold ? hold_q : resolved;
        end
    end
endmodule

// File: rtl/id_operand_latch.sv
// rtl/id_operand_latch.sv - ID-stage operand resolver with load-use detection and stall freeze
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : id_operand_latch_if.slave (flush, stall bus, operand sources, EX load info,
//          final rs/rt operands and load-use stall request)
module id_operand_latch
    import id_operand_latch_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int STALL_W = DEFAULT_STALL_W,
    parameter int ID_BIT  = DEFAULT_ID_BIT
) (
    input  logic             clk,
    input  logic             rst,
    id_operand_latch_if.slave bus
);
    lat_state_e state;
    logic       stall_id;
    logic       load_hit;
    logic       clear;
    logic       capture;
    logic       sel_hold;
    logic       unused_stall_bits;

    assign stall_id = bus.stall[ID_BIT];
    // Only the ID bit matters here; the rest of the bus is consumed elsewhere.
    assign unused_stall_bits = &{1'b0, bus.stall};

    assign load_hit = bus.ex_load_i &&
        ((bus.rs_re_i && (bus.rs_raddr_i != '0) && (bus.rs_raddr_i == bus.ex_load_waddr_i)) ||
         (bus.rt_re_i && (bus.rt_raddr_i != '0) && (bus.rt_raddr_i == bus.ex_load_waddr_i)));

    assign clear    = rst || bus.flush;
    assign sel_hold = (state == ST_HOLD);
    // Freeze only on the RUN/LWAIT -> HOLD edge, and never on a load-use cycle:
    // the operand resolved then still carries the pre-load value.
    assign capture  = !clear && !sel_hold && !load_hit && stall_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (bus.flush) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN, ST_LWAIT: begin
                    if (load_hit)      state <= ST_LWAIT;
                    else if (stall_id) state <= ST_HOLD;
                    else               state <= ST_RUN;
                end
                ST_HOLD: begin
                    state <= stall_id ? ST_HOLD : ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.stallreq_load_o = load_hit && !sel_hold && !rst && !bus.flush;

    id_operand_latch_operand_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_mux (
        .clk      (clk),
        .clear    (clear),
        .capture  (capture),
        .sel_hold (sel_hold),
        .kill     (rst),
        .raddr    (bus.rs_raddr_i),
        .sel_fwd  (bus.sel_rs_forward_i),
        .fwd_data (bus.rs_forward_data_i),
        .rf_rdata (bus.rs_rf_rdata_i),
        .data_o   (bus.rs_data_o)
    );

    id_operand_latch_operand_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_mux (
        .clk      (clk),
        .clear    (clear),
        .capture  (capture),
        .sel_hold (sel_hold),
        .kill     (rst),
        .raddr    (bus.rt_raddr_i),
        .sel_fwd  (bus.sel_rt_forward_i),
        .fwd_data (bus.rt_forward_data_i),
        .rf_rdata (bus.rt_rf_rdata_i),
        .data_o   (bus.rt_data_o)
    );
endmodule
